// File: rtl/debug_mem_arbiter.sv
// Debug-to-memory bridge: buffers one JTAG debug access, arbitrates it against
// CPU traffic on a shared single-port data memory, and returns read data.
module debug_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int DBG_PRIORITY = 0,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_we,
  input  logic              dbg_re,
  input  logic              dbg_clr_err,
  output logic              dbg_busy,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              dbg_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    RWAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic                req_we_q, req_we_d;
  logic [7:0]          starve_q, starve_d;
  logic [2:0]          lat_q, lat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                overrun_q, overrun_d;
  logic                strobe;
  logic                grant;

  assign strobe = dbg_we | dbg_re;
  assign grant  = (state_q == PEND) &&
                  ((DBG_PRIORITY != 0) || !cpu_req || (starve_q == 8'(STARVE_LIMIT)));

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_we_q    <= 1'b0;
      starve_q    <= '0;
      lat_q       <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_we_q    <= req_we_d;
      starve_q    <= starve_d;
      lat_q       <= lat_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_we_d    = req_we_q;
    starve_d    = starve_q;
    lat_d       = lat_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    overrun_d   = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          // Write wins when both strobes arrive together.
          req_addr_d  = dbg_addr;
          req_wdata_d = dbg_wdata;
          req_we_d    = dbg_we;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (grant) begin
          starve_d = '0;
          if (req_we_q) begin
            state_d = IDLE;
          end else begin
            state_d = RWAIT;
            lat_d   = 3'(RD_LATENCY);
          end
        end else begin
          starve_d = starve_q + 8'd1;
        end
      end
      RWAIT: begin
        lat_d = lat_q - 3'd1;
        // Counter reaches 1 in the cycle RD_LATENCY after the grant.
        if (lat_q == 3'd1) begin
          rdata_d  = mem_rdata;
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (strobe && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (dbg_clr_err) begin
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    mem_en    = cpu_req;
    mem_we    = cpu_req & cpu_we;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    if (grant) begin
      mem_en    = 1'b1;
      mem_we    = req_we_q;
      mem_addr  = req_addr_q;
      mem_wdata = req_wdata_q;
      cpu_stall = cpu_req;
    end
  end

  assign dbg_busy    = (state_q != IDLE);
  assign dbg_rdata   = rdata_q;
  assign dbg_rvalid  = rvalid_q;
  assign dbg_overrun = overrun_q;

endmodule

// File: tb/tb_debug_mem_arbiter.sv
// Directed bench: instance A (wait-for-idle, STARVE_LIMIT=3, RD_LATENCY=2)
// and instance B (debug priority) share CPU/memory inputs.
module tb_debug_mem_arbiter;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_we_a, dbg_re_a, dbg_we_b, dbg_re_b, dbg_clr_err;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, mem_rdata;

  logic        busy_a, rvalid_a, ovr_a, stall_a, en_a, we_a;
  logic [31:0] rdata_a, maddr_a, mwdata_a;
  logic        busy_b, rvalid_b, ovr_b, stall_b, en_b, we_b;
  logic [31:0] rdata_b, maddr_b, mwdata_b;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 cpu_clk = ~cpu_clk;

  debug_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(2),
                      .DBG_PRIORITY(0), .STARVE_LIMIT(3)) u_a (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we_a), .dbg_re(dbg_re_a),
    .dbg_clr_err(dbg_clr_err), .dbg_busy(busy_a), .dbg_rdata(rdata_a),
    .dbg_rvalid(rvalid_a), .dbg_overrun(ovr_a),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(stall_a), .mem_en(en_a), .mem_we(we_a), .mem_addr(maddr_a),
    .mem_wdata(mwdata_a), .mem_rdata(mem_rdata)
  );

  debug_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1),
                      .DBG_PRIORITY(1), .STARVE_LIMIT(3)) u_b (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we_b), .dbg_re(dbg_re_b),
    .dbg_clr_err(dbg_clr_err), .dbg_busy(busy_b), .dbg_rdata(rdata_b),
    .dbg_rvalid(rvalid_b), .dbg_overrun(ovr_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(stall_b), .mem_en(en_b), .mem_we(we_b), .mem_addr(maddr_b),
    .mem_wdata(mwdata_b), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge cpu_clk);
    #1;
    dbg_we_a = 1'b0; dbg_re_a = 1'b0; dbg_we_b = 1'b0; dbg_re_b = 1'b0;
    dbg_clr_err = 1'b0;
  endtask

  task automatic sample();
    @(negedge cpu_clk);
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    cpu_rstn = 1'b0;
    dbg_addr = '0; dbg_wdata = '0;
    dbg_we_a = 1'b0; dbg_re_a = 1'b0; dbg_we_b = 1'b0; dbg_re_b = 1'b0;
    dbg_clr_err = 1'b0; mem_rdata = '0;
    cpu_drive(1'b0, 1'b0, '0, '0);

    // Reset state
    sample();
    check("rst_busy",   64'(busy_a),   64'd0);
    check("rst_rvalid", 64'(rvalid_a), 64'd0);
    check("rst_ovr",    64'(ovr_a),    64'd0);
    check("rst_rdata",  64'(rdata_a),  64'd0);
    check("rst_mem_en", 64'(en_a),     64'd0);
    next_cycle();
    cpu_rstn = 1'b1;
    next_cycle();

    // Write with CPU idle
    dbg_we_a = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hA5A5A5A5;
    sample();
    check("wr_strobe_busy", 64'(busy_a), 64'd0);
    check("wr_strobe_en",   64'(en_a),   64'd0);
    next_cycle();
    sample();
    check("wr_grant_en",    64'(en_a),     64'd1);
    check("wr_grant_we",    64'(we_a),     64'd1);
    check("wr_grant_addr",  64'(maddr_a),  64'h10);
    check("wr_grant_data",  64'(mwdata_a), 64'hA5A5A5A5);
    check("wr_grant_busy",  64'(busy_a),   64'd1);
    check("wr_grant_stall", 64'(stall_a),  64'd0);
    next_cycle();
    sample();
    check("wr_done_busy", 64'(busy_a), 64'd0);
    check("wr_done_en",   64'(en_a),   64'd0);

    // Read, RD_LATENCY=2, CPU write passes through during RWAIT
    next_cycle();
    dbg_re_a = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'hDEAD;
    next_cycle();
    sample();
    check("rd_grant_en",   64'(en_a),    64'd1);
    check("rd_grant_we",   64'(we_a),    64'd0);
    check("rd_grant_addr", 64'(maddr_a), 64'h20);
    next_cycle();
    cpu_drive(1'b1, 1'b1, 32'h44, 32'h55);
    sample();
    check("rwait_cpu_en",    64'(en_a),     64'd1);
    check("rwait_cpu_we",    64'(we_a),     64'd1);
    check("rwait_cpu_addr",  64'(maddr_a),  64'h44);
    check("rwait_cpu_data",  64'(mwdata_a), 64'h55);
    check("rwait_cpu_stall", 64'(stall_a),  64'd0);
    check("rwait_busy",      64'(busy_a),   64'd1);
    next_cycle();
    cpu_drive(1'b0, 1'b0, '0, '0);
    mem_rdata = 32'h12345678;
    sample();
    check("rwait2_rvalid", 64'(rvalid_a), 64'd0);
    next_cycle();
    mem_rdata = 32'h0;
    sample();
    check("rd_rdata",  64'(rdata_a),  64'h12345678);
    check("rd_rvalid", 64'(rvalid_a), 64'd1);
    check("rd_busy",   64'(busy_a),   64'd0);
    next_cycle();
    sample();
    check("rd_rvalid_drop", 64'(rvalid_a), 64'd0);
    check("rd_rdata_hold",  64'(rdata_a),  64'h12345678);

    // Starvation: CPU busy, grant on 4th PEND cycle
    next_cycle();
    cpu_drive(1'b1, 1'b0, 32'h80, 32'h0);
    dbg_we_a = 1'b1; dbg_addr = 32'h30; dbg_wdata = 32'h77;
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      sample();
      check($sformatf("starve_p%0d_stall", i), 64'(stall_a), 64'd0);
      check($sformatf("starve_p%0d_addr", i),  64'(maddr_a), 64'h80);
    end
    next_cycle();
    sample();
    check("starve_p4_stall", 64'(stall_a), 64'd1);
    check("starve_p4_addr",  64'(maddr_a), 64'h30);
    check("starve_p4_we",    64'(we_a),    64'd1);
    next_cycle();
    sample();
    check("starve_after_stall", 64'(stall_a), 64'd0);
    check("starve_after_busy",  64'(busy_a),  64'd0);

    // Debug priority: instance B grants on the first PEND cycle
    next_cycle();
    dbg_we_b = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h99;
    next_cycle();
    sample();
    check("prio_stall", 64'(stall_b), 64'd1);
    check("prio_en",    64'(en_b),    64'd1);
    check("prio_addr",  64'(maddr_b), 64'h40);
    next_cycle();
    sample();
    check("prio_after_stall", 64'(stall_b), 64'd0);
    check("prio_after_busy",  64'(busy_b),  64'd0);

    // Overrun: strobe while PEND is dropped
    next_cycle();
    dbg_we_a = 1'b1; dbg_addr = 32'h50; dbg_wdata = 32'h5050;
    next_cycle();
    dbg_re_a = 1'b1; dbg_addr = 32'h58;
    sample();
    check("ovr_pend_stall", 64'(stall_a), 64'd0);
    next_cycle();
    cpu_drive(1'b0, 1'b0, '0, '0);
    sample();
    check("ovr_set",        64'(ovr_a),    64'd1);
    check("ovr_grant_addr", 64'(maddr_a),  64'h50);
    check("ovr_grant_we",   64'(we_a),     64'd1);
    check("ovr_grant_data", 64'(mwdata_a), 64'h5050);
    next_cycle();
    sample();
    check("ovr_no_extra_en", 64'(en_a),   64'd0);
    check("ovr_idle_busy",   64'(busy_a), 64'd0);
    check("ovr_sticky",      64'(ovr_a),  64'd1);
    dbg_clr_err = 1'b1;
    next_cycle();
    sample();
    check("ovr_cleared", 64'(ovr_a), 64'd0);

    // Simultaneous we+re: only the write goes out
    next_cycle();
    dbg_we_a = 1'b1; dbg_re_a = 1'b1; dbg_addr = 32'h60; dbg_wdata = 32'h1234;
    next_cycle();
    sample();
    check("werd_en",   64'(en_a),    64'd1);
    check("werd_we",   64'(we_a),    64'd1);
    check("werd_addr", 64'(maddr_a), 64'h60);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sample();
      check($sformatf("werd_idle%0d_en", i),     64'(en_a),     64'd0);
      check($sformatf("werd_idle%0d_rvalid", i), 64'(rvalid_a), 64'd0);
    end

    // Reset while PEND discards the buffered request
    next_cycle();
    cpu_drive(1'b1, 1'b0, 32'h90, 32'h0);
    dbg_we_a = 1'b1; dbg_addr = 32'h70; dbg_wdata = 32'h7070;
    next_cycle();
    sample();
    check("rstp_pend_busy", 64'(busy_a), 64'd1);
    next_cycle();
    cpu_rstn = 1'b0;
    cpu_drive(1'b0, 1'b0, '0, '0);
    sample();
    check("rstp_busy",   64'(busy_a),   64'd0);
    check("rstp_en",     64'(en_a),     64'd0);
    check("rstp_stall",  64'(stall_a),  64'd0);
    check("rstp_rdata",  64'(rdata_a),  64'd0);
    check("rstp_rvalid", 64'(rvalid_a), 64'd0);
    check("rstp_ovr",    64'(ovr_a),    64'd0);
    next_cycle();
    cpu_rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      sample();
      check($sformatf("rstp_after%0d_en", i), 64'(en_a), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
